// File: rtl/sha256_pkg.sv
// Constants and FSM encoding shared between the SHA-256 message padder and the compression core.
package sha256_pkg;

  localparam int         SHA_BLOCK_WORDS = 16;
  localparam logic [7:0] SHA_PAD_BYTE    = 8'h80;
  localparam logic [5:0] SHA_LEN_POS     = 6'd56;

  typedef enum logic [1:0] {
    S_MSG,
    S_PAD80,
    S_ZERO,
    S_LEN
  } pad_state_e;

  // Byte idx of the 64-bit length field, MSB first (idx 0 -> bits[63:56]).
  function automatic logic [7:0] len_byte(input logic [63:0] bits, input logic [2:0] idx);
    logic [5:0] sh;
    sh = {3'(3'd7 - idx), 3'b000};
    return 8'(bits >> sh);
  endfunction

endpackage

// File: rtl/sha256_byte_packer.sv
// Packs a byte-per-cycle stream into big-endian 32-bit words behind a one-entry valid/ready slot,
// tagging each word with its position inside the 16-word block.
module sha256_byte_packer
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        byte_len_last,
  input  logic        out_ready,
  output logic        slot_free,
  output logic        out_valid,
  output logic [31:0] out_word,
  output logic        out_first,
  output logic        out_block_end,
  output logic        out_msg_end
);

  // Only the three pending bytes need storage; the fourth arrives with the load.
  logic [23:0] sr_q, sr_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        valid_q, valid_d;
  logic [31:0] word_q, word_d;
  logic        first_q, first_d;
  logic        bend_q, bend_d;
  logic        mend_q, mend_d;

  always_comb begin
    slot_free = !valid_q | out_ready;
    sr_d      = sr_q;
    idx_d     = idx_q;
    wcnt_d    = wcnt_q;
    valid_d   = valid_q;
    word_d    = word_q;
    first_d   = first_q;
    bend_d    = bend_q;
    mend_d    = mend_q;

    if (valid_q && out_ready) valid_d = 1'b0;

    if (byte_valid && slot_free) begin
      if (idx_q == 2'd3) begin
        word_d  = {sr_q, byte_data};
        valid_d = 1'b1;
        first_d = (wcnt_q == 4'd0);
        bend_d  = (wcnt_q == 4'(SHA_BLOCK_WORDS - 1));
        mend_d  = (wcnt_q == 4'(SHA_BLOCK_WORDS - 1)) & byte_len_last;
        wcnt_d  = wcnt_q + 4'd1;
        idx_d   = 2'd0;
      end else begin
        sr_d  = {sr_q[15:0], byte_data};
        idx_d = idx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q    <= '0;
      idx_q   <= '0;
      wcnt_q  <= '0;
      valid_q <= 1'b0;
      word_q  <= '0;
      first_q <= 1'b0;
      bend_q  <= 1'b0;
      mend_q  <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      valid_q <= valid_d;
      word_q  <= word_d;
      first_q <= first_d;
      bend_q  <= bend_d;
      mend_q  <= mend_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_word      = word_q;
  assign out_first     = first_q;
  assign out_block_end = bend_q;
  assign out_msg_end   = mend_q;

endmodule

// File: rtl/sha256_msg_padder.sv
// Turns a raw message byte stream into FIPS 180-4 padded 512-bit blocks for the SHA-256 core.
// The FSM generates one byte per cycle (message, 0x80, zero fill, length) into the packer.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic        in_empty,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        out_first,
  output logic        out_block_end,
  output logic        out_msg_end,
  output logic        busy
);

  localparam int CNT_W = LEN_W - 3;

  pad_state_e       state_q, state_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [5:0]       blk_pos_q, blk_pos_d;
  logic [2:0]       len_idx_q, len_idx_d;
  logic             in_msg_q, in_msg_d;

  logic             slot_free;
  logic             gen_valid;
  logic [7:0]       gen_byte;
  logic             gen_len_last;
  logic [63:0]      len_bits;

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    blk_pos_d    = blk_pos_q;
    len_idx_d    = len_idx_q;
    in_msg_d     = in_msg_q;
    gen_valid    = 1'b0;
    gen_byte     = 8'h00;
    gen_len_last = 1'b0;
    len_bits     = 64'({byte_cnt_q, 3'b000});
    in_ready     = (state_q == S_MSG) & slot_free & !reset;

    unique case (state_q)
      S_MSG: begin
        // An empty beat without in_last is dropped: accepted, no state change.
        if (in_valid && in_ready) begin
          if (!in_empty) begin
            gen_valid  = 1'b1;
            gen_byte   = in_data;
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
            blk_pos_d  = blk_pos_q + 6'd1;
            in_msg_d   = 1'b1;
          end
          if (in_last) begin
            state_d  = S_PAD80;
            in_msg_d = 1'b0;
          end
        end
      end
      S_PAD80: begin
        if (slot_free) begin
          gen_valid = 1'b1;
          gen_byte  = SHA_PAD_BYTE;
          blk_pos_d = blk_pos_q + 6'd1;
          state_d   = S_ZERO;
        end
      end
      S_ZERO: begin
        // When 0x80 landed past the length slot this wraps through 63 -> 0 into a fresh block.
        if (slot_free) begin
          if (blk_pos_q == SHA_LEN_POS) begin
            state_d = S_LEN;
          end else begin
            gen_valid = 1'b1;
            blk_pos_d = blk_pos_q + 6'd1;
          end
        end
      end
      S_LEN: begin
        if (slot_free) begin
          gen_valid = 1'b1;
          gen_byte  = len_byte(len_bits, len_idx_q);
          blk_pos_d = blk_pos_q + 6'd1;
          len_idx_d = len_idx_q + 3'd1;
          if (len_idx_q == 3'd7) begin
            gen_len_last = 1'b1;
            byte_cnt_d   = '0;
            blk_pos_d    = '0;
            len_idx_d    = '0;
            state_d      = S_MSG;
          end
        end
      end
      default: state_d = S_MSG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_MSG;
      byte_cnt_q <= '0;
      blk_pos_q  <= '0;
      len_idx_q  <= '0;
      in_msg_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      blk_pos_q  <= blk_pos_d;
      len_idx_q  <= len_idx_d;
      in_msg_q   <= in_msg_d;
    end
  end

  sha256_byte_packer u_packer (
    .clk           (clk),
    .reset         (reset),
    .byte_valid    (gen_valid),
    .byte_data     (gen_byte),
    .byte_len_last (gen_len_last),
    .out_ready     (out_ready),
    .slot_free     (slot_free),
    .out_valid     (out_valid),
    .out_word      (out_word),
    .out_first     (out_first),
    .out_block_end (out_block_end),
    .out_msg_end   (out_msg_end)
  );

  // Busy covers data intake, padding, and the final word still waiting in the output slot.
  assign busy = (state_q != S_MSG) | in_msg_q | (out_valid & out_msg_end);

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Randomized bench for sha256_msg_padder: a queue-based FIPS 180-4 padding model feeds a scoreboard.
module tb_sha256_msg_padder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_empty;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_first;
  logic        out_block_end;
  logic        out_msg_end;
  logic        busy;

  typedef logic [7:0] bq_t[$];

  int          errors = 0;
  int          checks = 0;
  int          rdy_mode = 0;
  logic [34:0] exp_q[$];
  logic [31:0] got_q[$];
  bit          hold_pend = 1'b0;
  logic [34:0] hold_val;
  logic [34:0] mon_e;

  sha256_msg_padder #(.LEN_W(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_last       (in_last),
    .in_empty      (in_empty),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_word      (out_word),
    .out_first     (out_first),
    .out_block_end (out_block_end),
    .out_msg_end   (out_msg_end),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Padding rule applied to the whole message: bytes, 0x80, zeros to 56 mod 64, 64-bit bit length.
  task automatic model(input bq_t d);
    bq_t         p;
    logic [63:0] bits;
    int          nw;
    p = d;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(d.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nw = p.size() / 4;
    for (int w = 0; w < nw; w++)
      exp_q.push_back({(w == nw - 1), (w % 16 == 15), (w % 16 == 0),
                       p[4*w], p[4*w+1], p[4*w+2], p[4*w+3]});
  endtask

  function automatic logic [31:0] gw(input int i);
    return (i < got_q.size()) ? got_q[i] : 32'hDEADBEEF;
  endfunction

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d, input bit last, input bit empty);
    int n;
    n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_last = last; in_empty = empty;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("beat_accept_timeout", 64'(in_ready), 64'(1));
  endtask

  task automatic drive(input bq_t d, input bit term, input bit empty_term, input bit rnd);
    for (int i = 0; i < d.size(); i++) begin
      if (rnd && $urandom_range(0, 3) == 0) idle();
      if (rnd && $urandom_range(0, 15) == 0) beat(8'($urandom), 1'b0, 1'b1);
      beat(d[i], term && !empty_term && (i == d.size() - 1), 1'b0);
    end
    if (term && empty_term) beat(8'($urandom), 1'b1, 1'b1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", 64'(n < 3000), 64'(1));
    repeat (2) @(negedge clk);
    chk("busy_idle_after_msg", 64'(busy), 64'(0));
  endtask

  task automatic send_msg(input bq_t d, input bit empty_term, input bit rnd);
    got_q.delete();
    model(d);
    drive(d, 1'b1, empty_term, rnd);
    idle();
    wait_drain();
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend)
          chk("hold_stable", 64'({out_valid, out_msg_end, out_block_end, out_first, out_word}),
              64'({1'b1, hold_val}));
        hold_pend = out_valid && !out_ready;
        hold_val  = {out_msg_end, out_block_end, out_first, out_word};
        if (out_valid) chk("busy_while_valid", 64'(busy), 64'(1));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_word", 64'(out_valid), 64'(0));
          end else begin
            mon_e = exp_q.pop_front();
            chk("word", 64'({out_msg_end, out_block_end, out_first, out_word}), 64'(mon_e));
          end
          got_q.push_back(out_word);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t         d;
    logic [31:0] held;
    int          n;

    reset = 1'b1; in_valid = 1'b1; in_data = 8'h5A; in_last = 1'b0; in_empty = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_word", 64'(out_word), 64'(0));
    chk("rst_flags", 64'({out_first, out_block_end, out_msg_end}), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'(1));
    rdy_mode = 1;

    d = {8'h61, 8'h62, 8'h63};
    send_msg(d, 1'b0, 1'b0);
    chk("abc_nwords", 64'(got_q.size()), 64'(16));
    chk("abc_w0", 64'(gw(0)), 64'h61626380);
    chk("abc_w15", 64'(gw(15)), 64'h18);

    d.delete();
    send_msg(d, 1'b1, 1'b0);
    chk("empty_nwords", 64'(got_q.size()), 64'(16));
    chk("empty_w0", 64'(gw(0)), 64'h80000000);
    chk("empty_w15", 64'(gw(15)), 64'h0);

    d.delete();
    for (int i = 0; i < 55; i++) d.push_back(8'h41);
    send_msg(d, 1'b0, 1'b1);
    chk("b55_nwords", 64'(got_q.size()), 64'(16));
    chk("b55_w13", 64'(gw(13)), 64'h41414180);
    chk("b55_w14", 64'(gw(14)), 64'h0);
    chk("b55_w15", 64'(gw(15)), 64'h1B8);

    d.push_back(8'h41);
    send_msg(d, 1'b0, 1'b1);
    chk("b56_nwords", 64'(got_q.size()), 64'(32));
    chk("b56_w14", 64'(gw(14)), 64'h80000000);
    chk("b56_w15", 64'(gw(15)), 64'h0);
    chk("b56_w31", 64'(gw(31)), 64'h1C0);

    // 64-byte message, output stalled for 10 cycles while word 3 is presented.
    rdy_mode = 0;
    d.delete();
    for (int i = 0; i < 64; i++) d.push_back(8'($urandom));
    got_q.delete();
    model(d);
    fork
      begin
        drive(d, 1'b1, 1'b0, 1'b0);
        idle();
      end
      begin
        n = 0;
        while (got_q.size() < 3 && n < 500) begin @(negedge clk); n++; end
        rdy_mode = 2;
        n = 0;
        @(negedge clk);
        while (!(out_valid && !out_ready) && n < 500) begin @(negedge clk); n++; end
        chk("stall_reached", 64'(n < 500), 64'(1));
        held = out_word;
        repeat (10) begin
          chk("stall_word", 64'(out_word), 64'(held));
          chk("stall_valid", 64'(out_valid), 64'(1));
          chk("stall_in_ready", 64'(in_ready), 64'(0));
          @(negedge clk);
        end
        rdy_mode = 0;
      end
    join
    wait_drain();
    chk("b64_nwords", 64'(got_q.size()), 64'(32));
    chk("b64_w16", 64'(gw(16)), 64'h80000000);
    chk("b64_w31", 64'(gw(31)), 64'h200);

    // Partial message of 20 bytes, then reset: nothing stale may reach the next message.
    d.delete();
    for (int i = 0; i < 20; i++) d.push_back(8'($urandom));
    for (int w = 0; w < 5; w++)
      exp_q.push_back({1'b0, 1'b0, (w == 0), d[4*w], d[4*w+1], d[4*w+2], d[4*w+3]});
    drive(d, 1'b0, 1'b0, 1'b0);
    idle();
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    chk("partial_drained", 64'(n < 500), 64'(1));
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    rdy_mode = 1;
    d = {8'h61, 8'h62, 8'h63};
    send_msg(d, 1'b0, 1'b0);
    chk("abc2_nwords", 64'(got_q.size()), 64'(16));
    chk("abc2_w0", 64'(gw(0)), 64'h61626380);
    chk("abc2_w15", 64'(gw(15)), 64'h18);

    // Back-to-back messages: second starts as soon as the first one's length is out.
    rdy_mode = 0;
    got_q.delete();
    d = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    model(d);
    drive(d, 1'b1, 1'b0, 1'b0);
    d = {8'hAA, 8'hBB};
    model(d);
    drive(d, 1'b1, 1'b0, 1'b0);
    idle();
    wait_drain();
    chk("b2b_nwords", 64'(got_q.size()), 64'(32));

    rdy_mode = 1;
    for (int m = 0; m < 12; m++) begin
      int  len;
      bit  et;
      len = $urandom_range(0, 140);
      et  = (len == 0) || ($urandom_range(0, 1) == 1);
      d.delete();
      for (int i = 0; i < len; i++) d.push_back(8'($urandom));
      send_msg(d, et, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
